mem_arbiter: RTL

Shares the single 128-bit line-wide main-memory port between the instruction cache (read-only line refills) and the data cache (dirty-line writebacks, line refills, uncached masked writes). It sits between both caches and the memory controller, and it serialises transactions. A dcache writeback+refill pair is an atomic two-phase sequence under one grant. When both caches are pending, grants are round-robin; when only one is pending, that one is granted.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 27 ++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the icache/dcache main-memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 128;
  localparam int MASK_W_DEF = LINE_W_DEF / 8;

  localparam logic [ADDR_W_DEF-1:0] LINE_ALIGN = 32'hFFFF_FFF0;

  localparam logic RR_IC = 1'b0;
  localparam logic RR_DC = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    IC_RD,
    DC_WR,
    DC_RD,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker; the pointer moves away from whichever side was granted.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic req_ic,
  input  logic req_dc,
  input  logic en,
  output logic grant_dc
);

  logic ptr_reg;

  always_comb begin
    grant_dc = req_dc & (~req_ic | (ptr_reg == RR_DC));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_reg <= RR_IC;
    end else if (en) begin
      ptr_reg <= grant_dc ? RR_IC : RR_DC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache refills and dcache writebacks/refills/uncached stores onto one line-wide memory port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF,
  parameter int MASK_W = MASK_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ic_rd,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [LINE_W-1:0] ic_data,
  output logic              ic_done,
  input  logic              dc_rd,
  input  logic              dc_wr,
  input  logic [ADDR_W-1:0] dc_rd_addr,
  input  logic [ADDR_W-1:0] dc_wr_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  input  logic [MASK_W-1:0] dc_wmask,
  output logic [LINE_W-1:0] dc_data,
  output logic              dc_done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [MASK_W-1:0] mem_mask,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_done
);

  // Built by inverting the offset bits so it stays correct for any address width.
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(~LINE_ALIGN);

  state_t            state_reg;
  logic              dc_rd_q_reg;
  logic              rd_issue_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic              grant_dc;
  logic              arb_en;

  assign arb_en = (state_reg == IDLE) && (ic_rd || dc_rd || dc_wr);

  rr_arbiter2 u_rr (
    .CLK      (CLK),
    .RST      (RST),
    .req_ic   (ic_rd),
    .req_dc   (dc_rd | dc_wr),
    .en       (arb_en),
    .grant_dc (grant_dc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      dc_rd_q_reg  <= 1'b0;
      rd_issue_reg <= 1'b0;
      rd_addr_reg  <= '0;
      ic_data      <= '0;
      ic_done      <= 1'b0;
      dc_data      <= '0;
      dc_done      <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_data_o   <= '0;
      mem_mask     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arb_en) begin
            if (grant_dc) begin
              dc_rd_q_reg <= dc_rd;
              rd_addr_reg <= dc_rd_addr & ALIGN;
              if (dc_wr) begin
                state_reg  <= DC_WR;
                mem_write  <= 1'b1;
                mem_addr   <= dc_wr_addr;
                mem_data_o <= dc_wdata;
                mem_mask   <= dc_wmask;
              end else begin
                state_reg <= DC_RD;
                mem_read  <= 1'b1;
                mem_addr  <= dc_rd_addr & ALIGN;
                mem_mask  <= '0;
              end
            end else begin
              state_reg <= IC_RD;
              mem_read  <= 1'b1;
              mem_addr  <= ic_addr & ALIGN;
              mem_mask  <= '0;
            end
          end
        end
        IC_RD: begin
          if (mem_done) begin
            ic_data   <= mem_data_i;
            ic_done   <= 1'b1;
            mem_read  <= 1'b0;
            state_reg <= RESP;
          end
        end
        DC_WR: begin
          if (mem_done) begin
            mem_write <= 1'b0;
            if (dc_rd_q_reg) begin
              state_reg    <= DC_RD;
              rd_issue_reg <= 1'b1;
            end else begin
              dc_done   <= 1'b1;
              state_reg <= RESP;
            end
          end
        end
        DC_RD: begin
          // After a writeback the refill waits one gap cycle before its command.
          if (rd_issue_reg) begin
            rd_issue_reg <= 1'b0;
            mem_read     <= 1'b1;
            mem_addr     <= rd_addr_reg;
            mem_mask     <= '0;
          end else if (mem_done) begin
            dc_data   <= mem_data_i;
            dc_done   <= 1'b1;
            mem_read  <= 1'b0;
            state_reg <= RESP;
          end
        end
        RESP: begin
          ic_done   <= 1'b0;
          dc_done   <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
